// File: rtl/parking_pkg.sv
// Shared definitions for the parking entry barrier: state encoding, counter
// widths and default timing parameters.
package parking_pkg;

  localparam int SEC_W   = 8;
  localparam int TRIES_W = 8;

  localparam int MOVE_SECS_DEF         = 3;
  localparam int PASS_TIMEOUT_SECS_DEF = 10;
  localparam int ALARM_SECS_DEF        = 5;
  localparam int MAX_TRIES_DEF         = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_ALARM   = 3'd4
  } state_t;

  // The barrier is in motion in these states; the warning lamp blinks only here.
  function automatic logic is_moving(state_t s);
    return (s == ST_OPENING) || (s == ST_CLOSING);
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Sensor/card-reader inputs and motor/LED outputs of the entry barrier.
interface parking_gate_ctrl_if;

  logic       car_present;
  logic       card_valid;
  logic       card_ok;
  logic       car_passed;
  logic       beam_blocked;
  logic       motor_open;
  logic       motor_close;
  logic       gate_open;
  logic       warn_led;
  logic       alarm;
  logic       entry_pulse;
  logic [2:0] state_o;

  modport master (
    output car_present, card_valid, card_ok, car_passed, beam_blocked,
    input  motor_open, motor_close, gate_open, warn_led, alarm, entry_pulse, state_o
  );

  modport slave (
    input  car_present, card_valid, card_ok, car_passed, beam_blocked,
    output motor_open, motor_close, gate_open, warn_led, alarm, entry_pulse, state_o
  );

endinterface

// File: rtl/tick_sync_edge.sv
// Brings a slow divider square wave into the clk_40MHz domain and turns each
// rising edge into a single-cycle tick, three cycles after the input edge.
module tick_sync_edge (
  input  logic clk_40MHz,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Two-flop synchroniser, delayed copy, and registered rising-edge pulse.
  always_ff @(posedge clk_40MHz) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      tick    <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry-barrier sequencer: card authorisation, open/close strokes timed in
// seconds, pass/timeout handling, bad-card alarm. All outputs are registered.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int MOVE_SECS         = MOVE_SECS_DEF,
  parameter int PASS_TIMEOUT_SECS = PASS_TIMEOUT_SECS_DEF,
  parameter int ALARM_SECS        = ALARM_SECS_DEF,
  parameter int MAX_TRIES         = MAX_TRIES_DEF
) (
  input  logic                clk_40MHz,
  input  logic                rst_n,
  input  logic                clk_1Hz,
  input  logic                clk_2Hz,
  parking_gate_ctrl_if.slave  bus
);

  logic               tick_1s;
  logic               tick_half;
  state_t             state_q, state_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic               entry_d, warn_d;
  logic               motor_open_q, motor_close_q, gate_open_q;
  logic               warn_q, alarm_q, entry_q;
  logic [2:0]         state_o_q;

  tick_sync_edge u_tick_1s (
    .clk_40MHz (clk_40MHz),
    .rst_n     (rst_n),
    .async_in  (clk_1Hz),
    .tick      (tick_1s)
  );

  tick_sync_edge u_tick_half (
    .clk_40MHz (clk_40MHz),
    .rst_n     (rst_n),
    .async_in  (clk_2Hz),
    .tick      (tick_half)
  );

  // Next-state, seconds counter, tries counter and next output values.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    tries_d = tries_q;
    entry_d = 1'b0;
    warn_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.card_valid && bus.car_present) begin
          if (bus.card_ok) begin
            state_d = ST_OPENING;
            tries_d = '0;
          end else begin
            tries_d = tries_q + 1'b1;
            if (tries_q == TRIES_W'(MAX_TRIES - 1)) state_d = ST_ALARM;
          end
        end
      end
      ST_OPENING: begin
        if (sec_q == SEC_W'(MOVE_SECS)) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        // A car clearing the barrier on the timeout cycle is still counted.
        if (bus.car_passed) begin
          state_d = ST_CLOSING;
          entry_d = 1'b1;
        end else if (sec_q == SEC_W'(PASS_TIMEOUT_SECS)) begin
          state_d = ST_CLOSING;
        end
      end
      ST_CLOSING: begin
        // Safety beam overrides a completed stroke: reopen fully.
        if (bus.beam_blocked) state_d = ST_OPENING;
        else if (sec_q == SEC_W'(MOVE_SECS)) state_d = ST_IDLE;
      end
      ST_ALARM: begin
        if (sec_q == SEC_W'(ALARM_SECS)) begin
          state_d = ST_IDLE;
          tries_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) sec_d = '0;
    else if (tick_1s && (sec_q != '1)) sec_d = sec_q + 1'b1;

    if (is_moving(state_q) && is_moving(state_d)) warn_d = warn_q ^ tick_half;
  end

  // State, counters and registered output decode.
  always_ff @(posedge clk_40MHz) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sec_q         <= '0;
      tries_q       <= '0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      gate_open_q   <= 1'b0;
      warn_q        <= 1'b0;
      alarm_q       <= 1'b0;
      entry_q       <= 1'b0;
      state_o_q     <= 3'd0;
    end else begin
      state_q       <= state_d;
      sec_q         <= sec_d;
      tries_q       <= tries_d;
      motor_open_q  <= (state_d == ST_OPENING);
      motor_close_q <= (state_d == ST_CLOSING);
      gate_open_q   <= (state_d == ST_OPEN);
      warn_q        <= warn_d;
      alarm_q       <= (state_d == ST_ALARM);
      entry_q       <= entry_d;
      state_o_q     <= state_d;
    end
  end

  assign bus.motor_open  = motor_open_q;
  assign bus.motor_close = motor_close_q;
  assign bus.gate_open   = gate_open_q;
  assign bus.warn_led    = warn_q;
  assign bus.alarm       = alarm_q;
  assign bus.entry_pulse = entry_q;
  assign bus.state_o     = state_o_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for the parking entry barrier sequencer.
module tb_parking_gate_ctrl;

  logic clk_40MHz = 1'b0;
  logic rst_n;
  logic clk_1Hz;
  logic clk_2Hz;
  int   n_chk  = 0;
  int   n_fail = 0;

  parking_gate_ctrl_if bus ();

  parking_gate_ctrl #(
    .MOVE_SECS         (3),
    .PASS_TIMEOUT_SECS (10),
    .ALARM_SECS        (5),
    .MAX_TRIES         (3)
  ) dut (
    .clk_40MHz (clk_40MHz),
    .rst_n     (rst_n),
    .clk_1Hz   (clk_1Hz),
    .clk_2Hz   (clk_2Hz),
    .bus       (bus)
  );

  always #5 clk_40MHz = ~clk_40MHz;

  // clk_1Hz period = 40 system cycles, clk_2Hz period = 20, offset from clk edges.
  initial begin
    clk_1Hz = 1'b0;
    #3;
    forever #200 clk_1Hz = ~clk_1Hz;
  end

  initial begin
    clk_2Hz = 1'b0;
    #3;
    forever #100 clk_2Hz = ~clk_2Hz;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] outs();
    return {bus.motor_open, bus.motor_close, bus.gate_open,
            bus.warn_led, bus.alarm, bus.entry_pulse};
  endfunction

  task automatic card(input logic ok);
    bus.card_valid = 1'b1;
    bus.card_ok    = ok;
    @(negedge clk_40MHz);
    bus.card_valid = 1'b0;
    bus.card_ok    = 1'b0;
  endtask

  task automatic pulse_passed();
    bus.car_passed = 1'b1;
    @(negedge clk_40MHz);
    bus.car_passed = 1'b0;
  endtask

  // Stay in state st, counting second ticks, warn activity and entry pulses.
  task automatic run_state(input logic [2:0] st, output int ticks, output logic saw_warn,
                           output int n_entry, output logic to);
    int cyc;
    cyc = 0; ticks = 0; saw_warn = 1'b0; n_entry = 0;
    while (bus.state_o == st && cyc < 1000) begin
      if (dut.tick_1s) ticks++;
      if (bus.warn_led) saw_warn = 1'b1;
      if (bus.entry_pulse) n_entry++;
      @(negedge clk_40MHz);
      cyc++;
    end
    to = (cyc >= 1000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.car_present = 0; bus.card_valid = 0; bus.card_ok = 0;
    bus.car_passed = 0; bus.beam_blocked = 0;
    repeat (4) @(negedge clk_40MHz);
    n_chk++; if (outs() !== 6'b0) begin n_fail++; $display("FAIL reset_outs: got %b expected 000000", outs()); end
    n_chk++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
    n_chk++; if (dut.sec_q !== 8'd0) begin n_fail++; $display("FAIL reset_sec: got %0d expected 0", dut.sec_q); end
    n_chk++; if (dut.tries_q !== 8'd0) begin n_fail++; $display("FAIL reset_tries: got %0d expected 0", dut.tries_q); end
    rst_n = 1'b1;
    @(negedge clk_40MHz);
  endtask

  task automatic test_tick_latency();
    @(posedge clk_1Hz);
    repeat (2) @(posedge clk_40MHz);
    @(negedge clk_40MHz);
    n_chk++; if (dut.tick_1s !== 1'b0) begin n_fail++; $display("FAIL tick_early: got %b expected 0", dut.tick_1s); end
    @(negedge clk_40MHz);
    n_chk++; if (dut.tick_1s !== 1'b1) begin n_fail++; $display("FAIL tick_lat3: got %b expected 1", dut.tick_1s); end
    @(negedge clk_40MHz);
    n_chk++; if (dut.tick_1s !== 1'b0) begin n_fail++; $display("FAIL tick_width: got %b expected 0", dut.tick_1s); end
  endtask

  task automatic test_entry();
    int t, ne; logic w, to;
    bus.car_present = 1'b1;
    card(1'b1);
    n_chk++; if (bus.state_o !== 3'd1) begin n_fail++; $display("FAIL t1_opening_state: got %0d expected 1", bus.state_o); end
    n_chk++; if ({bus.motor_open, bus.motor_close} !== 2'b10) begin n_fail++; $display("FAIL t1_motor_open: got %b expected 10", {bus.motor_open, bus.motor_close}); end
    run_state(3'd1, t, w, ne, to);
    n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL t1_open_timeout: got %b expected 0", to); end
    n_chk++; if (t !== 3) begin n_fail++; $display("FAIL t1_open_ticks: got %0d expected 3", t); end
    n_chk++; if (w !== 1'b1) begin n_fail++; $display("FAIL t1_warn_blink: got %b expected 1", w); end
    n_chk++; if ({bus.state_o, outs()} !== {3'd2, 6'b001000}) begin n_fail++; $display("FAIL t1_open: got %0d/%b expected 2/001000", bus.state_o, outs()); end
    repeat (3) @(negedge clk_40MHz);
    pulse_passed();
    n_chk++; if ({bus.state_o, outs()} !== {3'd3, 6'b010001}) begin n_fail++; $display("FAIL t1_closing: got %0d/%b expected 3/010001", bus.state_o, outs()); end
    run_state(3'd3, t, w, ne, to);
    n_chk++; if (t !== 3 || to !== 1'b0) begin n_fail++; $display("FAIL t1_close_ticks: got %0d expected 3", t); end
    n_chk++; if (ne !== 1) begin n_fail++; $display("FAIL t1_entry_count: got %0d expected 1", ne); end
    n_chk++; if ({bus.state_o, outs()} !== {3'd0, 6'b0}) begin n_fail++; $display("FAIL t1_idle: got %0d/%b expected 0/000000", bus.state_o, outs()); end
    bus.car_present = 1'b0;
  endtask

  task automatic test_timeout();
    int t, ne; logic w, to;
    bus.car_present = 1'b1;
    card(1'b1);
    run_state(3'd1, t, w, ne, to);
    n_chk++; if (bus.state_o !== 3'd2) begin n_fail++; $display("FAIL t2_open_state: got %0d expected 2", bus.state_o); end
    run_state(3'd2, t, w, ne, to);
    n_chk++; if (t !== 10 || to !== 1'b0) begin n_fail++; $display("FAIL t2_timeout_ticks: got %0d expected 10", t); end
    n_chk++; if (bus.state_o !== 3'd3) begin n_fail++; $display("FAIL t2_closing: got %0d expected 3", bus.state_o); end
    run_state(3'd3, t, w, ne, to);
    n_chk++; if (ne !== 0) begin n_fail++; $display("FAIL t2_no_entry: got %0d expected 0", ne); end
    n_chk++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL t2_idle: got %0d expected 0", bus.state_o); end
    bus.car_present = 1'b0;
  endtask

  task automatic test_alarm();
    int t, ne; logic w, to;
    bus.car_present = 1'b1;
    card(1'b0);
    n_chk++; if ({bus.state_o, dut.tries_q} !== {3'd0, 8'd1}) begin n_fail++; $display("FAIL t3_try1: got %0d/%0d expected 0/1", bus.state_o, dut.tries_q); end
    @(negedge clk_40MHz);
    card(1'b0);
    n_chk++; if ({bus.state_o, dut.tries_q} !== {3'd0, 8'd2}) begin n_fail++; $display("FAIL t3_try2: got %0d/%0d expected 0/2", bus.state_o, dut.tries_q); end
    @(negedge clk_40MHz);
    card(1'b0);
    n_chk++; if ({bus.state_o, bus.alarm} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL t3_alarm: got %0d/%b expected 4/1", bus.state_o, bus.alarm); end
    card(1'b1);
    run_state(3'd4, t, w, ne, to);
    n_chk++; if (t !== 5 || to !== 1'b0) begin n_fail++; $display("FAIL t3_alarm_ticks: got %0d expected 5", t); end
    n_chk++; if ({bus.state_o, bus.alarm, dut.tries_q} !== {3'd0, 1'b0, 8'd0}) begin n_fail++; $display("FAIL t3_release: got %0d/%b/%0d expected 0/0/0", bus.state_o, bus.alarm, dut.tries_q); end
    bus.car_present = 1'b0;
  endtask

  task automatic test_beam();
    int t, ne, cyc; logic w, to;
    bus.car_present = 1'b1;
    card(1'b1);
    run_state(3'd1, t, w, ne, to);
    pulse_passed();
    cyc = 0;
    while (dut.sec_q != 8'd1 && bus.state_o == 3'd3 && cyc < 200) begin
      @(negedge clk_40MHz);
      cyc++;
    end
    n_chk++; if ({bus.state_o, dut.sec_q} !== {3'd3, 8'd1}) begin n_fail++; $display("FAIL t4_sec1: got %0d/%0d expected 3/1", bus.state_o, dut.sec_q); end
    bus.beam_blocked = 1'b1;
    @(negedge clk_40MHz);
    bus.beam_blocked = 1'b0;
    n_chk++; if ({bus.state_o, bus.motor_open, bus.motor_close} !== {3'd1, 2'b10}) begin n_fail++; $display("FAIL t4_reopen: got %0d/%b expected 1/10", bus.state_o, {bus.motor_open, bus.motor_close}); end
    n_chk++; if (dut.sec_q !== 8'd0) begin n_fail++; $display("FAIL t4_sec_clear: got %0d expected 0", dut.sec_q); end
    run_state(3'd1, t, w, ne, to);
    n_chk++; if (t !== 3 || to !== 1'b0) begin n_fail++; $display("FAIL t4_full_stroke: got %0d expected 3", t); end
    pulse_passed();
    run_state(3'd3, t, w, ne, to);
    n_chk++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL t4_idle: got %0d expected 0", bus.state_o); end
    bus.car_present = 1'b0;
  endtask

  task automatic test_pass_at_timeout();
    int t, ne, cyc; logic w, to;
    bus.car_present = 1'b1;
    card(1'b1);
    run_state(3'd1, t, w, ne, to);
    cyc = 0;
    while (dut.sec_q != 8'd10 && bus.state_o == 3'd2 && cyc < 1000) begin
      @(negedge clk_40MHz);
      cyc++;
    end
    n_chk++; if ({bus.state_o, dut.sec_q} !== {3'd2, 8'd10}) begin n_fail++; $display("FAIL t5_at_timeout: got %0d/%0d expected 2/10", bus.state_o, dut.sec_q); end
    pulse_passed();
    n_chk++; if ({bus.state_o, bus.entry_pulse} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL t5_pass_wins: got %0d/%b expected 3/1", bus.state_o, bus.entry_pulse); end
    run_state(3'd3, t, w, ne, to);
    n_chk++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL t5_idle: got %0d expected 0", bus.state_o); end
    bus.car_present = 1'b0;
  endtask

  task automatic test_reset_mid_stroke();
    bus.car_present = 1'b1;
    card(1'b1);
    repeat (10) @(negedge clk_40MHz);
    n_chk++; if (bus.motor_open !== 1'b1) begin n_fail++; $display("FAIL t5_mid_opening: got %b expected 1", bus.motor_open); end
    rst_n = 1'b0;
    @(negedge clk_40MHz);
    n_chk++; if ({bus.state_o, outs()} !== {3'd0, 6'b0}) begin n_fail++; $display("FAIL t5_reset_mid: got %0d/%b expected 0/000000", bus.state_o, outs()); end
    rst_n = 1'b1;
    bus.car_present = 1'b0;
    @(negedge clk_40MHz);
  endtask

  task automatic test_no_car();
    bus.car_present = 1'b1;
    card(1'b0);
    bus.car_present = 1'b0;
    card(1'b0);
    n_chk++; if ({bus.state_o, dut.tries_q} !== {3'd0, 8'd1}) begin n_fail++; $display("FAIL t6_bad_no_car: got %0d/%0d expected 0/1", bus.state_o, dut.tries_q); end
    card(1'b1);
    n_chk++; if ({bus.state_o, dut.tries_q} !== {3'd0, 8'd1}) begin n_fail++; $display("FAIL t6_ok_no_car: got %0d/%0d expected 0/1", bus.state_o, dut.tries_q); end
    repeat (25) @(negedge clk_40MHz);
    n_chk++; if (outs() !== 6'b0) begin n_fail++; $display("FAIL t6_idle_outs: got %b expected 000000", outs()); end
  endtask

  initial begin
    test_reset();
    test_tick_latency();
    test_entry();
    test_timeout();
    test_alarm();
    test_beam();
    test_pass_at_timeout();
    test_reset_mid_stroke();
    test_no_car();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
